// File: rtl/sys_control.sv
// sys_control: per-key debouncers, reset sequencer (POR hold / optional user reset) and heartbeat.
// Build option: define SYSCTL_KEY_RST_EN to let a debounced press on key[0] act as a user reset.

module sys_control #(
    parameter int unsigned NKEYS      = 2,
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned POR_CYCLES = 16,
    parameter int unsigned HB_DIV     = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] key,
    output logic             sys_rst,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release,
    output logic             hb,
    output logic             hb_tick,
    output logic             rst_led
);

    localparam int unsigned DebW = $clog2(DEB_CYCLES) + 1;
    localparam int unsigned PorW = $clog2(POR_CYCLES);
    localparam int unsigned HbW  = $clog2(HB_DIV);

    localparam logic [DebW-1:0] DebMax  = DebW'(DEB_CYCLES);
    localparam logic [PorW-1:0] PorLast = PorW'(POR_CYCLES - 1);
    localparam logic [HbW-1:0]  HbLast  = HbW'(HB_DIV - 1);

`ifdef SYSCTL_KEY_RST_EN
    typedef enum logic [1:0] {StHold, StRun, StKeyRst} state_e;
`else
    typedef enum logic [0:0] {StHold, StRun} state_e;
`endif

    // Synchronisers hold the pressed polarity (1 = pressed).
    logic [NKEYS-1:0] sync1_q, sync2_q;
    logic [NKEYS-1:0] level_d, press_d, release_d;
    logic [DebW-1:0]  cnt_q [NKEYS];
    logic [DebW-1:0]  cnt_d [NKEYS];

    state_e           state_q;
    logic [PorW-1:0]  hold_q;
    logic [HbW-1:0]   hb_cnt_q;

    always_comb begin
        level_d   = key_level;
        press_d   = '0;
        release_d = '0;
        for (int k = 0; k < NKEYS; k++) begin
            cnt_d[k] = '0;
            if (sync2_q[k] != key_level[k]) begin
                if (cnt_q[k] == DebMax) begin
                    level_d[k]   = sync2_q[k];
                    press_d[k]   = sync2_q[k];
                    release_d[k] = ~sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            for (int k = 0; k < NKEYS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            sync1_q     <= ~key;
            sync2_q     <= sync1_q;
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
            cnt_q       <= cnt_d;
        end
    end

    // The sequencer looks at the debouncer's next level so the user reset tracks key_level
    // on the same edge it changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StHold;
            hold_q  <= '0;
            sys_rst <= 1'b1;
            rst_led <= 1'b1;
        end else begin
            case (state_q)
                StHold: begin
                    if (hold_q == PorLast) begin
                        state_q <= StRun;
                        hold_q  <= '0;
                        sys_rst <= 1'b0;
                        rst_led <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                StRun: begin
`ifdef SYSCTL_KEY_RST_EN
                    if (level_d[0]) begin
                        state_q <= StKeyRst;
                        hold_q  <= '0;
                        sys_rst <= 1'b1;
                        rst_led <= 1'b1;
                    end
`endif
                end
`ifdef SYSCTL_KEY_RST_EN
                StKeyRst: begin
                    hold_q <= '0;
                    if (!level_d[0]) begin
                        state_q <= StHold;
                    end
                end
`endif
                default: begin
                    state_q <= StHold;
                    hold_q  <= '0;
                    sys_rst <= 1'b1;
                    rst_led <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_cnt_q <= '0;
            hb       <= 1'b0;
            hb_tick  <= 1'b0;
        end else if (sys_rst) begin
            hb_cnt_q <= '0;
            hb       <= 1'b0;
            hb_tick  <= 1'b0;
        end else begin
            hb_tick <= 1'b0;
            if (hb_cnt_q == HbLast) begin
                hb_cnt_q <= '0;
                hb       <= ~hb;
                hb_tick  <= ~hb;
            end else begin
                hb_cnt_q <= hb_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sys_control.sv
// Self-checking bench for sys_control with a window-based debounce model and
// arithmetic reset/heartbeat timing model.

module tb_sys_control;

    localparam int NK  = 2;
    localparam int DEB = 4;
    localparam int POR = 8;
    localparam int HB  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NK-1:0] key = 2'b11;
    logic          sys_rst, hb, hb_tick, rst_led;
    logic [NK-1:0] key_level, key_press, key_release;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [NK-1:0] hist[$];
    logic [NK-1:0] exp_level, exp_press, exp_release;
    logic          exp_sys_rst;
    int            n_hold;
    int            hbt;
    bit            keyrst;

    always #5 clk = ~clk;

    sys_control #(
        .NKEYS     (NK),
        .DEB_CYCLES(DEB),
        .POR_CYCLES(POR),
        .HB_DIV    (HB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .sys_rst    (sys_rst),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .hb         (hb),
        .hb_tick    (hb_tick),
        .rst_led    (rst_led)
    );

    function automatic logic exp_hb();
        return ((hbt / HB) % 2) == 1;
    endfunction

    function automatic logic exp_tick();
        return (hbt % (2 * HB)) == HB;
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (DEB + 2) hist.push_back('0);
        exp_level   = '0;
        exp_press   = '0;
        exp_release = '0;
        n_hold      = 0;
        hbt         = 0;
        keyrst      = 0;
        exp_sys_rst = 1'b1;
    endtask

    // One clock: drive key, advance DUT and model, return at the falling edge.
    task automatic step(input logic [NK-1:0] k);
        logic prev_rst;
        int   last;
        bit   diff;
        key = k;
        hist.push_back(~k);
        @(posedge clk);
        prev_rst    = exp_sys_rst;
        last        = hist.size() - 1;
        exp_press   = '0;
        exp_release = '0;
        // A key flips once its pressed value has differed from the level for DEB+1 samples,
        // the newest of which is two edges old (synchroniser delay).
        for (int i = 0; i < NK; i++) begin
            diff = 1;
            for (int j = 2; j <= DEB + 2; j++) begin
                if (hist[last-j][i] == exp_level[i]) diff = 0;
            end
            if (diff) begin
                exp_level[i] = ~exp_level[i];
                if (exp_level[i]) exp_press[i] = 1'b1;
                else exp_release[i] = 1'b1;
            end
        end
`ifdef SYSCTL_KEY_RST_EN
        if (keyrst) begin
            if (!exp_level[0]) begin
                keyrst = 0;
                n_hold = 0;
            end
        end else if (n_hold >= POR && exp_level[0]) begin
            keyrst = 1;
        end else if (n_hold < POR) begin
            n_hold++;
        end
`else
        if (n_hold < POR) n_hold++;
`endif
        exp_sys_rst = keyrst || (n_hold < POR);
        hbt = prev_rst ? 0 : hbt + 1;
        if (hist.size() > 32) void'(hist.pop_front());
        @(negedge clk);
    endtask

    task automatic assert_rst();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sys_rst, rst_led, key_level, key_press, key_release, hb, hb_tick} !== 10'b11_00_00_00_00) begin
            errors++;
            $display("FAIL reset_async: got %b want 1100000000",
                     {sys_rst, rst_led, key_level, key_press, key_release, hb, hb_tick});
        end
        key = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({sys_rst, rst_led, key_level, key_press, key_release, hb, hb_tick} !== 10'b11_00_00_00_00) begin
            errors++;
            $display("FAIL reset_held: got %b want 1100000000",
                     {sys_rst, rst_led, key_level, key_press, key_release, hb, hb_tick});
        end
        key = 2'b11;
        release_rst();
        for (int i = 1; i <= 12; i++) begin
            step(2'b11);
            checks++;
            if ({sys_rst, rst_led} !== {exp_sys_rst, exp_sys_rst}) begin
                errors++;
                $display("FAIL por_hold cyc %0d: got sys_rst/rst_led %b%b want %b", i, sys_rst, rst_led,
                         exp_sys_rst);
            end
        end
    endtask

    task automatic test_heartbeat();
        int rises = 0;
        for (int i = 0; i < 40; i++) begin
            step(2'b11);
            if (hb_tick === 1'b1) rises++;
            checks++;
            if ({sys_rst, hb, hb_tick} !== {exp_sys_rst, exp_hb(), exp_tick()}) begin
                errors++;
                $display("FAIL heartbeat cyc %0d: got rst/hb/tick %b%b%b want %b%b%b", i, sys_rst, hb, hb_tick,
                         exp_sys_rst, exp_hb(), exp_tick());
            end
        end
        checks++;
        if (rises != 4) begin
            errors++;
            $display("FAIL heartbeat_ticks: got %0d want 4", rises);
        end
    endtask

    task automatic test_press_hold();
        int presses = 0;
        for (int i = 0; i < 12; i++) begin
            step(2'b01);
            if (key_press[1] === 1'b1) presses++;
            checks++;
            if ({key_level, key_press, key_release} !== {exp_level, exp_press, exp_release}) begin
                errors++;
                $display("FAIL press_hold cyc %0d: got lvl/prs/rel %b/%b/%b want %b/%b/%b", i, key_level,
                         key_press, key_release, exp_level, exp_press, exp_release);
            end
        end
        checks++;
        if (presses != 1 || key_level[1] !== 1'b1) begin
            errors++;
            $display("FAIL press_once: got %0d pulses level %b want 1 pulse level 1", presses, key_level[1]);
        end
        for (int i = 0; i < 10; i++) step(2'b11);
        checks++;
        if (key_level !== 2'b00) begin
            errors++;
            $display("FAIL release_level: got %b want 00", key_level);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 6; i++) begin
                step(i < 3 ? 2'b01 : 2'b11);
                pulses += $countones({key_press, key_release});
                checks++;
                if ({key_level, key_press, key_release} !== {exp_level, exp_press, exp_release}) begin
                    errors++;
                    $display("FAIL bounce r%0d c%0d: got %b/%b/%b want %b/%b/%b", r, i, key_level, key_press,
                             key_release, exp_level, exp_press, exp_release);
                end
            end
        end
        checks++;
        if (pulses != 0 || key_level !== 2'b00) begin
            errors++;
            $display("FAIL bounce_quiet: got %0d pulses level %b want 0 pulses level 00", pulses, key_level);
        end
    endtask

    task automatic test_random();
        logic [NK-1:0] k = 2'b11;
        int            run = 0;
        for (int i = 0; i < 400; i++) begin
            if (run == 0) begin
                k   = NK'($urandom);
`ifdef SYSCTL_KEY_RST_EN
                k[0] = 1'b1;
`endif
                run = $urandom_range(1, 9);
            end
            run--;
            step(k);
            checks++;
            if ({key_level, key_press, key_release, sys_rst, hb, hb_tick} !==
                {exp_level, exp_press, exp_release, exp_sys_rst, exp_hb(), exp_tick()}) begin
                errors++;
                $display("FAIL random cyc %0d: got %b/%b/%b rst%b hb%b%b want %b/%b/%b rst%b hb%b%b", i,
                         key_level, key_press, key_release, sys_rst, hb, hb_tick, exp_level, exp_press,
                         exp_release, exp_sys_rst, exp_hb(), exp_tick());
            end
            checks++;
            if ((key_press & key_release) !== '0) begin
                errors++;
                $display("FAIL press_release_excl cyc %0d: got %b want 00", i, key_press & key_release);
            end
        end
        for (int i = 0; i < 10; i++) step(2'b11);
    endtask

    task automatic test_rst_mid();
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step(2'b11);
            if (!exp_sys_rst && exp_hb() && (hbt % (2 * HB)) == HB + 1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_mid_setup: got no hb high phase want one within 60 cycles");
        end
        step(2'b01);
        step(2'b01);
        step(2'b01);
        assert_rst();
        checks++;
        if ({sys_rst, rst_led, key_level, key_press, key_release, hb, hb_tick} !== 10'b11_00_00_00_00) begin
            errors++;
            $display("FAIL rst_mid_async: got %b want 1100000000",
                     {sys_rst, rst_led, key_level, key_press, key_release, hb, hb_tick});
        end
        release_rst();
        // key[1] stays pressed through release and must still be reported.
        for (int i = 0; i < 16; i++) begin
            step(2'b01);
            checks++;
            if ({sys_rst, rst_led, key_level, key_press, hb} !==
                {exp_sys_rst, exp_sys_rst, exp_level, exp_press, exp_hb()}) begin
                errors++;
                $display("FAIL rst_mid_restart cyc %0d: got %b want %b", i,
                         {sys_rst, rst_led, key_level, key_press, hb},
                         {exp_sys_rst, exp_sys_rst, exp_level, exp_press, exp_hb()});
            end
        end
        for (int i = 0; i < 10; i++) step(2'b11);
    endtask

`ifdef SYSCTL_KEY_RST_EN
    task automatic test_key0();
        int rst_cycles = 0;
        for (int i = 0; i < 40 && exp_sys_rst; i++) step(2'b11);
        for (int i = 0; i < 45; i++) begin
            step(i < 20 ? 2'b10 : 2'b11);
            if (sys_rst === 1'b1) rst_cycles++;
            checks++;
            if ({sys_rst, rst_led, hb, hb_tick, key_level} !==
                {exp_sys_rst, exp_sys_rst, exp_hb(), exp_tick(), exp_level}) begin
                errors++;
                $display("FAIL key_rst cyc %0d: got %b want %b", i, {sys_rst, rst_led, hb, hb_tick, key_level},
                         {exp_sys_rst, exp_sys_rst, exp_hb(), exp_tick(), exp_level});
            end
        end
        checks++;
        if (rst_cycles != 20 + POR) begin
            errors++;
            $display("FAIL key_rst_len: got %0d want %0d", rst_cycles, 20 + POR);
        end
    endtask
`else
    task automatic test_key0();
        int presses = 0;
        for (int i = 0; i < 20; i++) begin
            step(i < 10 ? 2'b10 : 2'b11);
            if (key_press[0] === 1'b1) presses++;
            checks++;
            if ({sys_rst, key_level, key_press, key_release} !==
                {exp_sys_rst, exp_level, exp_press, exp_release}) begin
                errors++;
                $display("FAIL key0_plain cyc %0d: got %b want %b", i,
                         {sys_rst, key_level, key_press, key_release},
                         {exp_sys_rst, exp_level, exp_press, exp_release});
            end
        end
        checks++;
        if (presses != 1) begin
            errors++;
            $display("FAIL key0_press: got %0d pulses want 1", presses);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_heartbeat();
        test_press_hold();
        test_bounce();
        test_random();
        test_rst_mid();
        test_key0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
